// File: rtl/mf8_spi_seq.sv
// mf8 IO-bus SPI master sequencer: mode 3, MSB first, one byte per DATA write.
// Optional writable clock divider at address 2 when MF8_SPI_SEQ_CLKDIV_EN is defined.
module mf8_spi_seq #(
    parameter logic [3:0] BASE = 4'h4
) (
    input  logic       CLK,
    input  logic       Reset_s_n,
    input  logic       IO_Wr,
    input  logic       IO_Rd,
    input  logic [5:0] IO_Addr,
    input  logic [7:0] IO_WData,
    output logic [7:0] IO_RData,
    input  logic       SPI_MISO,
    output logic       SPI_MOSI,
    output logic       SPI_SCK,
    output logic       SPI_CS
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  rxdata_q, rxdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        ovr_q, ovr_d;
    logic        cs_q, cs_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;

    logic [7:0]  div;
    logic        sel, busy, half_done;
    logic        wr_data, wr_ctrl, wr_div, rd_status;

    assign sel       = (IO_Addr[5:2] == BASE);
    assign busy      = (state_q != ST_IDLE);
    assign wr_data   = IO_Wr && sel && (IO_Addr[1:0] == 2'd0);
    assign wr_ctrl   = IO_Wr && sel && (IO_Addr[1:0] == 2'd1);
    assign rd_status = IO_Rd && sel && (IO_Addr[1:0] == 2'd1);

`ifdef MF8_SPI_SEQ_CLKDIV_EN
    logic [7:0] div_q, div_d;

    assign wr_div = IO_Wr && sel && (IO_Addr[1:0] == 2'd2);

    always_comb begin
        div_d = div_q;
        if (wr_div && !busy) div_d = IO_WData;
    end

    always_ff @(posedge CLK or negedge Reset_s_n) begin
        if (!Reset_s_n) div_q <= 8'h00;
        else            div_q <= div_d;
    end

    assign div = div_q;
`else
    assign wr_div = 1'b0;
    assign div    = 8'h00;
`endif

    assign half_done = (cnt_q == div);

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        rxdata_d = rxdata_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        ovr_d    = ovr_q;
        cs_d     = cs_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;

        // A set in the same cycle as a STATUS read must survive, so it comes last.
        if (rd_status) ovr_d = 1'b0;
        if (busy && (wr_data || wr_ctrl || wr_div)) ovr_d = 1'b1;

        if (wr_ctrl && !busy) cs_d = IO_WData[7];

        case (state_q)
            ST_IDLE: begin
                if (wr_data) begin
                    shreg_d  = IO_WData;
                    bitcnt_d = 3'd7;
                    cnt_d    = 8'h00;
                    sck_d    = 1'b0;
                    mosi_d   = IO_WData[7];
                    state_d  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (half_done) begin
                    cnt_d   = 8'h00;
                    sck_d   = 1'b1;
                    shreg_d = {shreg_q[6:0], SPI_MISO};
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (half_done) begin
                    cnt_d = 8'h00;
                    if (bitcnt_q != 3'd0) begin
                        bitcnt_d = bitcnt_q - 3'd1;
                        sck_d    = 1'b0;
                        mosi_d   = shreg_q[7];
                        state_d  = ST_LOW;
                    end else begin
                        rxdata_d = shreg_q;
                        mosi_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled at the same edge.
    always_ff @(posedge CLK or negedge Reset_s_n) begin
        if (!Reset_s_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= 8'h00;
            rxdata_q <= 8'h00;
            cnt_q    <= 8'h00;
            bitcnt_q <= 3'd0;
            ovr_q    <= 1'b0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b1;
            mosi_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            rxdata_q <= rxdata_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            ovr_q    <= ovr_d;
            cs_q     <= cs_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
        end
    end

    always_comb begin
        IO_RData = 8'h00;
        if (sel) begin
            case (IO_Addr[1:0])
                2'd0:    IO_RData = rxdata_q;
                2'd1:    IO_RData = {cs_q, 5'b0, ovr_q, busy};
                2'd2:    IO_RData = div;
                default: IO_RData = 8'h00;
            endcase
        end
    end

    assign SPI_CS   = cs_q;
    assign SPI_SCK  = sck_q;
    assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_mf8_spi_seq.sv
// Directed bench for mf8_spi_seq: queued MOSI/RX expectations, slave MISO model,
// phase/length timing, overrun, address decode and asynchronous reset abort.
module tb_mf8_spi_seq;

    logic       CLK = 1'b0;
    logic       Reset_s_n;
    logic       IO_Wr, IO_Rd;
    logic [5:0] IO_Addr;
    logic [7:0] IO_WData;
    logic [7:0] IO_RData;
    logic       SPI_MISO, SPI_MOSI, SPI_SCK, SPI_CS;

    int vectors     = 0;
    int miscompares = 0;

    bit         exp_bits[$];
    logic [7:0] exp_rx[$];

    mf8_spi_seq #(.BASE(4'h4)) dut (
        .CLK       (CLK),
        .Reset_s_n (Reset_s_n),
        .IO_Wr     (IO_Wr),
        .IO_Rd     (IO_Rd),
        .IO_Addr   (IO_Addr),
        .IO_WData  (IO_WData),
        .IO_RData  (IO_RData),
        .SPI_MISO  (SPI_MISO),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_SCK   (SPI_SCK),
        .SPI_CS    (SPI_CS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        IO_Rd = 1'b0; IO_Addr = a; IO_WData = d; IO_Wr = 1'b1;
        @(negedge CLK);
        IO_Wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [7:0] expv);
        logic [7:0] d;
        IO_Wr = 1'b0; IO_Addr = a; IO_Rd = 1'b1;
        #1 d = IO_RData;
        @(negedge CLK);
        IO_Rd = 1'b0;
        check(tag, d, expv);
    endtask

    // Starts a byte at a negedge and follows it sample by sample until BUSY drops.
    // inj >= 0 plants the overrun accesses at that sample; abort resets after 3 rises.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] slv, input int div,
                            input int inj, input bit abort);
        logic prev_sck, sck, busy;
        int   run, rises, busy_n, miso_idx;
        bit   run_valid;
        for (int i = 7; i >= 0; i--) exp_bits.push_back(tx[i]);
        exp_rx.push_back(abort ? 8'h00 : slv);
        IO_Rd = 1'b0; IO_Addr = 6'h10; IO_WData = tx; IO_Wr = 1'b1;
        @(negedge CLK);
        prev_sck = 1'b1; run = 0; run_valid = 1'b0; rises = 0; busy_n = 0; miso_idx = 7;
        for (int n = 0; n < 16 * (div + 1) + 40; n++) begin
            IO_Wr = 1'b0; IO_Rd = 1'b0; IO_Addr = 6'h11;
            #1;
            busy = IO_RData[0];
            sck  = SPI_SCK;
            if (sck !== prev_sck) begin
                if (run_valid) check(prev_sck ? "high_len" : "low_len", run, div + 1);
                run_valid = 1'b1;
                run = 1;
                if (sck === 1'b0) begin
                    check("mosi_bit", SPI_MOSI, exp_bits.pop_front());
                    if (miso_idx >= 0) SPI_MISO = slv[miso_idx];
                    miso_idx--;
                end else begin
                    rises++;
                end
            end else begin
                run++;
            end
            prev_sck = sck;
            if (abort && rises == 3) begin
                Reset_s_n = 1'b0;
                #1;
                check("rst_pins", {SPI_CS, SPI_SCK, SPI_MOSI}, 3'b111);
                check("rst_status", IO_RData, 8'h80);
                exp_bits.delete();
                repeat (2) @(negedge CLK);
                Reset_s_n = 1'b1;
                return;
            end
            if (busy !== 1'b1) break;
            busy_n++;
            if (inj >= 0 && n == inj) begin
                IO_Addr = 6'h10; IO_WData = 8'h11; IO_Wr = 1'b1;
            end else if (inj >= 0 && n == inj + 1) begin
                IO_Addr = 6'h11; IO_WData = 8'h80; IO_Wr = 1'b1;
            end else if (inj >= 0 && n == inj + 2) begin
                IO_Addr = 6'h11; IO_WData = 8'h80; IO_Wr = 1'b1; IO_Rd = 1'b1;
                #1 check("ovr_status_busy", IO_RData, 8'h03);
            end
            @(negedge CLK);
        end
        IO_Wr = 1'b0; IO_Rd = 1'b0;
        check("busy_cycles", busy_n, 16 * (div + 1));
        check("sck_rises", rises, 8);
        check("idle_pins", {SPI_SCK, SPI_MOSI}, 2'b11);
    endtask

    initial begin
        int lows;
        Reset_s_n = 1'b0;
        IO_Wr = 1'b0; IO_Rd = 1'b0; IO_Addr = 6'h00; IO_WData = 8'h00;
        SPI_MISO = 1'b1;
        repeat (3) @(negedge CLK);
        Reset_s_n = 1'b1;
        @(negedge CLK);

        // Reset state
        check("reset_pins", {SPI_CS, SPI_SCK, SPI_MOSI}, 3'b111);
        rd_chk("reset_status", 6'h11, 8'h80);
        rd_chk("reset_data", 6'h10, 8'h00);
        rd_chk("reset_div", 6'h12, 8'h00);

        // CS control and divider register presence
        io_write(6'h11, 8'h00);
        check("cs_low", SPI_CS, 1'b0);
        io_write(6'h12, 8'h03);
`ifdef MF8_SPI_SEQ_CLKDIV_EN
        rd_chk("div_rb", 6'h12, 8'h03);
        io_write(6'h12, 8'h00);
`else
        rd_chk("div_absent", 6'h12, 8'h00);
`endif
        rd_chk("status_no_ovr", 6'h11, 8'h00);

        // Basic transfer and a second pattern back to back
        run_xfer(8'hA5, 8'h3C, 0, -1, 1'b0);
        rd_chk("rx_basic", 6'h10, exp_rx.pop_front());
        run_xfer(8'h81, 8'h7E, 0, -1, 1'b0);
        rd_chk("rx_second", 6'h10, exp_rx.pop_front());
        rd_chk("status_idle", 6'h11, 8'h00);

`ifdef MF8_SPI_SEQ_CLKDIV_EN
        io_write(6'h12, 8'h03);
        run_xfer(8'hFF, 8'h55, 3, -1, 1'b0);
        rd_chk("rx_div", 6'h10, exp_rx.pop_front());
        io_write(6'h12, 8'h00);
        rd_chk("div_restored", 6'h12, 8'h00);
`endif

        // Overrun: DATA and CTRL writes mid-byte are dropped, OVR sticks
        run_xfer(8'h5A, 8'hC3, 0, 4, 1'b0);
        check("ovr_cs_held", SPI_CS, 1'b0);
        rd_chk("ovr_status_after", 6'h11, 8'h02);
        rd_chk("ovr_cleared", 6'h11, 8'h00);
        rd_chk("rx_ovr", 6'h10, exp_rx.pop_front());

        // Address decode: aliases of DATA/CTRL outside the window do nothing
        io_write(6'h20, 8'hA5);
        io_write(6'h14, 8'hA5);
        io_write(6'h21, 8'h80);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (SPI_SCK !== 1'b1) lows++;
            @(negedge CLK);
        end
        check("decode_no_sck", lows, 0);
        check("decode_cs", SPI_CS, 1'b0);
        rd_chk("decode_status", 6'h11, 8'h00);
        rd_chk("decode_rd_20", 6'h20, 8'h00);
        rd_chk("decode_rd_14", 6'h14, 8'h00);

        // Reset mid-transfer
        run_xfer(8'hF0, 8'h96, 0, -1, 1'b1);
        @(negedge CLK);
        rd_chk("rx_after_abort", 6'h10, exp_rx.pop_front());
        rd_chk("status_after_abort", 6'h11, 8'h80);
        check("pins_after_abort", {SPI_CS, SPI_SCK, SPI_MOSI}, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mf8_spi_seq.md
# mf8_spi_seq

- Hardware SPI master sequencer on the mf8 core IO bus. It replaces firmware bit-banging of SPI_CS/SPI_SCK/SPI_MOSI/SPI_MISO.
- The core writes one byte and the block shifts it out in SPI mode 3, MSB first, while capturing MISO. Firmware polls a busy flag.
- Sits between `mf8_core` IO_* signals and the SPI pins in the MF8 top level.

## Interface

Parameters:
- BASE, 4'h4, block selected when IO_Addr[5:2] == BASE (IO 0x10–0x13)

Ports:
- CLK  in  1  system clock
- Reset_s_n  in  1  reset, asynchronous, active-low
- IO_Wr  in  1  IO write strobe from core, one cycle
- IO_Rd  in  1  IO read strobe from core, one cycle
- IO_Addr  in  6  IO address
- IO_WData  in  8  IO write data
- IO_RData  out  8  IO read data, combinational; 8'h00 when not selected
- SPI_MISO  in  1  serial input from slave
- SPI_MOSI  out  1  serial output, idle high
- SPI_SCK  out  1  serial clock, idle high (mode 3)
- SPI_CS  out  1  chip select, active-low, firmware controlled

## Operation

Register map (IO_Addr[1:0]):
- 0 DATA: write starts a transfer; read returns the last received byte.
- 1 STATUS/CTRL:
  - Read: {CS, 5'b0, OVR, BUSY}.
  - Write: bit7 → SPI_CS.
- 2 DIV: SCK half-period is DIV+1 CLK cycles (see Configuration).
- 3: reads 8'h00; writes ignored.

State machine:
- IDLE:
  - A DATA write loads the shift register and bit count 7, and sets BUSY.
  - Next state LOW. SCK=0 and MOSI=data[7] at that same edge.
- LOW: holds DIV+1 cycles, then goes to HIGH. At the exit edge, SCK=1 and MISO is shifted into shreg[0].
- HIGH: holds DIV+1 cycles.
  - If bit count > 0: decrement, go to LOW, SCK=0, MOSI=next bit.
  - If bit count == 0: go to IDLE. Set rxdata=shreg, BUSY=0, MOSI=1.

Boundary rules:
- DATA or CTRL write while BUSY: ignored; sets OVR (sticky). SPI_CS never changes mid-byte.
- DIV write while BUSY: ignored; sets OVR.
- STATUS read (IO_Rd and addr 1): clears OVR at end of cycle. If a set occurs in the same cycle, the set wins.
- DATA write in the same cycle BUSY falls: BUSY is still 1 that cycle, so the write is ignored and OVR is set.
- Unselected addresses: no state change; IO_RData=8'h00.
- Reset asserted mid-transfer: immediate abort; all registers go to reset values; no partial rxdata update.

## Timing

Reset values:
- SPI_CS=1, SPI_SCK=1, SPI_MOSI=1.
- BUSY=0, OVR=0, rxdata=8'h00, DIV=8'h00.

Transfer timing:
- Transfer length from the write edge to BUSY=0 is exactly 16×(DIV+1) CLK cycles.
- First SCK falling edge coincides with the write edge (registered, +0 cycles after IO_Wr sampled).
- MISO is sampled at the CLK edge that drives SCK 0→1. The slave must have MISO stable one CLK before that edge.
- rxdata and BUSY=0 update at the same edge. A STATUS read showing BUSY=0 guarantees DATA is valid.

Read/write timing:
- IO_RData is combinational from registers, valid in the IO_Rd cycle.
- Back-to-back transfers: earliest next DATA write is the cycle after BUSY=0 is observed. SCK stays high ≥1 cycle between bytes.

## Configuration

- MF8_SPI_SEQ_CLKDIV_EN defined: DIV is a writable 8-bit register at address 2. Half-period is DIV+1, range 1–256 cycles.
- Undefined: no DIV register. Half-period is fixed at 1 cycle, so a byte takes 16 cycles. Address 2 reads 8'h00 and writes are ignored without setting OVR.

## Test plan

- Reset:
  - Stimulus: after reset release, read STATUS.
  - Required: 8'h80. SCK=MOSI=CS=1.
- Basic transfer:
  - Stimulus: DIV=0, write CTRL 8'h00 then DATA 8'hA5; slave model returns 8'h3C.
  - Required: MOSI bits 1,0,1,0,0,1,0,1 on falling edges; BUSY for exactly 16 cycles; DATA read = 8'h3C.
- Divider (macro on):
  - Stimulus: DIV=8'h03, write DATA 8'hFF.
  - Required: SCK low/high phases of 4 cycles each; BUSY for 64 cycles.
- Overrun:
  - Stimulus: during a transfer, write DATA 8'h11 and CTRL 8'h80.
  - Required: shifted byte unchanged; CS stays 0; STATUS reads 8'h03 while busy; after BUSY clears STATUS reads 8'h02, and a second STATUS read returns 8'h00.
- Reset mid-transfer:
  - Stimulus: assert Reset_s_n low after the 3rd SCK rising edge.
  - Required: outputs return to reset values asynchronously; DATA reads 8'h00 after release.
- Address decode:
  - Stimulus: IO writes to 0x20 and 0x14.
  - Required: no SPI activity; IO_RData=8'h00 for those addresses.
